// File: rtl/pic32_bus_ctrl_if.sv
// Parallel-link signal bundle between the PIC32 (master) and the FPGA controller (slave).
interface pic32_bus_ctrl_if;
  logic        locked;
  logic [7:0]  port_e;
  logic        strobe;
  logic        phase;
  logic [3:0]  port_d_out;
  logic [7:0]  leds;
  logic [11:0] display;

  modport slave (
    input  locked, port_e, strobe, phase,
    output port_d_out, leds, display
  );

  modport master (
    output locked, port_e, strobe, phase,
    input  port_d_out, leds, display
  );
endinterface

// File: rtl/pic32_bus_ctrl.sv
// Slave controller for the PIC32 parallel link: synchronised strobe decode into a 4-entry register bank.
// Optional macro PIC32_BUS_AUTO_INC_EN: post-increment the register address after every data write.
module pic32_bus_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_SETTLE    = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
  pic32_bus_ctrl_if.slave  bus
);
  localparam int SW = $clog2(LOCK_SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {WAIT_LOCK, IDLE, GOT_ADDR, WRITE} state_t;

  state_t          state, next_state;
  logic [9:0]      sync_p [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] lock_p;
  logic            strobe_prev;
  logic [SW-1:0]   settle;
  logic [TW-1:0]   tmo;
  logic [1:0]      address;
  logic [7:0]      data_q;
  logic [7:0]      regs [4];
  logic            ack, error, busy, ready;

  logic       lock_s, s_phase, s_strobe, strobe_rise, addr_ok, timed_out, settled, accept;
  logic [7:0] s_byte;

  assign lock_s      = lock_p[SYNC_STAGES-1];
  assign s_phase     = sync_p[SYNC_STAGES-1][9];
  assign s_strobe    = sync_p[SYNC_STAGES-1][8];
  assign s_byte      = sync_p[SYNC_STAGES-1][7:0];
  assign strobe_rise = s_strobe & ~strobe_prev;
  assign addr_ok     = (s_byte[7:2] == 6'd0);
  assign timed_out   = (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign settled     = (settle == SW'(LOCK_SETTLE - 1));
  assign accept      = lock_s && strobe_rise && (state == IDLE || state == GOT_ADDR);

  // Stage p0..pN: phase/strobe/byte travel together so they stay aligned after sync
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      lock_p      <= '0;
      strobe_prev <= 1'b0;
    end else begin
      sync_p[0] <= {bus.phase, bus.strobe, bus.port_e};
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      lock_p      <= {lock_p[SYNC_STAGES-2:0], bus.locked};
      strobe_prev <= s_strobe;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= WAIT_LOCK;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_LOCK: if (lock_s && settled) next_state = IDLE;
      IDLE: begin
        if (!lock_s)                                   next_state = WAIT_LOCK;
        else if (strobe_rise && !s_phase && addr_ok)   next_state = GOT_ADDR;
      end
      GOT_ADDR: begin
        if (!lock_s)                next_state = WAIT_LOCK;
        else if (strobe_rise)       next_state = s_phase ? WRITE : GOT_ADDR;
        else if (timed_out)         next_state = IDLE;
      end
      WRITE: next_state = lock_s ? GOT_ADDR : WAIT_LOCK;
      default: next_state = WAIT_LOCK;
    endcase
  end

  always_comb begin
    busy  = (state == GOT_ADDR) || (state == WRITE);
    ready = (state != WAIT_LOCK);
  end

  // Ack toggles when the edge is taken; the register update lands one cycle later in WRITE
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      settle  <= '0;
      tmo     <= '0;
      address <= 2'd0;
      data_q  <= 8'd0;
      ack     <= 1'b0;
      error   <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
    end else begin
      settle <= (state == WAIT_LOCK && lock_s && !settled) ? settle + 1'b1 : '0;
      tmo    <= (state == GOT_ADDR && !strobe_rise) ? tmo + 1'b1 : '0;

      if (accept) begin
        ack    <= ~ack;
        data_q <= s_byte;
        if (!s_phase) begin
          if (addr_ok) begin
            address <= s_byte[1:0];
            error   <= 1'b0;
          end else begin
            error <= 1'b1;
          end
        end else if (state == IDLE) begin
          error <= 1'b1;
        end
      end

      if (lock_s && state == GOT_ADDR && !strobe_rise && timed_out) error <= 1'b1;

      if (lock_s && state == WRITE) begin
        regs[address] <= (address == 2'd2) ? {4'd0, data_q[3:0]} : data_q;
`ifdef PIC32_BUS_AUTO_INC_EN
        address <= address + 2'd1;
`else
        address <= address;
`endif
      end
    end
  end

  assign bus.port_d_out = {ready, error, busy, ack};
  assign bus.leds       = regs[0];
  assign bus.display    = {regs[2][3:0], regs[1]};

endmodule

// File: tb/tb_pic32_bus_ctrl.sv
// Directed bench for pic32_bus_ctrl: lock settle, address/data decode, errors, timeout, lock loss, reset.
module tb_pic32_bus_ctrl;
  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  int   n;

  pic32_bus_ctrl_if bus_if ();

  pic32_bus_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clock = ~clock;

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic ph, input logic [7:0] b);
    bus_if.port_e = b;
    bus_if.phase  = ph;
    bus_if.strobe = 1'b1;
    tick(4);
    bus_if.strobe = 1'b0;
    tick(4);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus_if.locked = 1'b1;
    bus_if.strobe = 1'b0;
    bus_if.phase  = 1'b0;
    bus_if.port_e = 8'h00;
    tick(3);
    chk("rst_pd", 32'(bus_if.port_d_out), 32'h0);
    chk("rst_leds", 32'(bus_if.leds), 32'h00);
    chk("rst_disp", 32'(bus_if.display), 32'h000);

    // Lock settle: ready after ~LOCK_SETTLE cycles
    reset_n = 1'b1;
    tick(250);
    n = 250;
    chk("settle_not_ready", 32'(bus_if.port_d_out), 32'h0);
    while (!bus_if.port_d_out[3] && n < 400) begin
      tick(1);
      n++;
    end
    chk("settle_len_ok", 32'(n >= 256 && n <= 262), 32'h1);
    chk("ready_pd", 32'(bus_if.port_d_out), 32'h8);
    chk("ready_leds", 32'(bus_if.leds), 32'h00);

    // Address 0, data A5
    send_byte(1'b0, 8'h00);
    chk("t2_addr_pd", 32'(bus_if.port_d_out), 32'hB);
    send_byte(1'b1, 8'hA5);
    chk("t2_data_pd", 32'(bus_if.port_d_out), 32'hA);
    chk("t2_leds", 32'(bus_if.leds), 32'hA5);

    // Address 2, data FF; bad address; good address clears error
    send_byte(1'b0, 8'h02);
    chk("t3_addr_pd", 32'(bus_if.port_d_out), 32'hB);
    send_byte(1'b1, 8'hFF);
    chk("t3_data_pd", 32'(bus_if.port_d_out), 32'hA);
    chk("t3_disp", 32'(bus_if.display), 32'hF00);
    chk("t3_leds", 32'(bus_if.leds), 32'hA5);
    send_byte(1'b0, 8'h07);
    chk("t3_bad_addr_pd", 32'(bus_if.port_d_out), 32'hF);
    send_byte(1'b0, 8'h01);
    chk("t3_readdr_pd", 32'(bus_if.port_d_out), 32'hA);

    // Timeout in GOT_ADDR
    send_byte(1'b0, 8'h00);
    chk("t4_addr_pd", 32'(bus_if.port_d_out), 32'hB);
    tick(500);
    chk("t4_wait_pd", 32'(bus_if.port_d_out), 32'hB);
    tick(600);
    chk("t4_timeout_pd", 32'(bus_if.port_d_out), 32'hD);
    send_byte(1'b1, 8'h5A);
    chk("t4_idle_data_pd", 32'(bus_if.port_d_out), 32'hC);
    chk("t4_idle_data_leds", 32'(bus_if.leds), 32'hA5);

    // Three data bytes after one address
    send_byte(1'b0, 8'h00);
    chk("t5_addr_pd", 32'(bus_if.port_d_out), 32'hB);
    send_byte(1'b1, 8'h11);
    send_byte(1'b1, 8'h22);
    send_byte(1'b1, 8'h33);
    chk("t5_pd", 32'(bus_if.port_d_out), 32'hA);
`ifdef PIC32_BUS_AUTO_INC_EN
    chk("t5_leds", 32'(bus_if.leds), 32'h11);
    chk("t5_disp", 32'(bus_if.display), 32'h322);
`else
    chk("t5_leds", 32'(bus_if.leds), 32'h33);
    chk("t5_disp", 32'(bus_if.display), 32'hF00);
`endif

    // Lock loss in GOT_ADDR, ignored strobe, relock
    bus_if.locked = 1'b0;
    tick(3);
    chk("t6_lost_pd", 32'(bus_if.port_d_out), 32'h0);
    send_byte(1'b0, 8'h01);
    chk("t6_relock_strobe_pd", 32'(bus_if.port_d_out), 32'h0);
    bus_if.locked = 1'b1;
    n = 0;
    while (!bus_if.port_d_out[3] && n < 300) begin
      tick(1);
      n++;
    end
    chk("t6_relock_len_ok", 32'(n >= 256 && n <= 262), 32'h1);
    chk("t6_relock_pd", 32'(bus_if.port_d_out), 32'h8);
`ifdef PIC32_BUS_AUTO_INC_EN
    chk("t6_leds", 32'(bus_if.leds), 32'h11);
`else
    chk("t6_leds", 32'(bus_if.leds), 32'h33);
`endif

    // Scratch register 3 has no visible output
    send_byte(1'b0, 8'h03);
    chk("t7_addr3_pd", 32'(bus_if.port_d_out), 32'hB);
    send_byte(1'b1, 8'h5A);
    chk("t7_data3_pd", 32'(bus_if.port_d_out), 32'hA);
`ifdef PIC32_BUS_AUTO_INC_EN
    chk("t7_leds", 32'(bus_if.leds), 32'h11);
    chk("t7_disp", 32'(bus_if.display), 32'h322);
`else
    chk("t7_leds", 32'(bus_if.leds), 32'h33);
    chk("t7_disp", 32'(bus_if.display), 32'hF00);
`endif

    // Reset mid-transfer
    reset_n = 1'b0;
    tick(1);
    chk("t8_rst_pd", 32'(bus_if.port_d_out), 32'h0);
    chk("t8_rst_leds", 32'(bus_if.leds), 32'h00);
    chk("t8_rst_disp", 32'(bus_if.display), 32'h000);
    reset_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
